decode_hazard_ctrl: RTL

Scoreboard-based hazard controller for the decode stage. It tracks outstanding register-file writes for all 16 architectural registers and stalls fetch/decode while a decoded instruction reads a register with a write still in flight. It also inserts bubbles toward execute and flushes the fetch slot on a taken branch. It sits beside the decode stage and observes the instruction word and the register-file write port.

---
 rtl/decode_hazard_ctrl.sv | 66 ++++++
 1 files changed

// File: rtl/decode_hazard_ctrl.sv
// decode_hazard_ctrl: scoreboard of in-flight register writes driving decode stalls, bubbles and branch flushes
module decode_hazard_ctrl #(
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dec_valid,
  input  logic [15:0] dec_inst,
  input  logic        dec_writes,
  input  logic        dec_uses_src2,
  input  logic        branchD,
  input  logic        branch_taken,
  input  logic        wb_en,
  input  logic [3:0]  wb_addr,
  output logic        stall_F,
  output logic        stall_D,
  output logic        bubble_E,
  output logic        flush_D,
  output logic        issue,
  output logic        pending_any,
  output logic        sb_err
);
  logic [CNT_W-1:0] cnt_q [16];
  logic [CNT_W-1:0] cnt_d [16];
  logic             sb_err_q, sb_err_d;
  logic [3:0]       src1, src2, dest;
  logic             hazard1, hazard2, full, stall;

  assign src1 = dec_inst[11:8];
  assign src2 = dec_inst[7:4];
  assign dest = dec_inst[3:0];

  // The last outstanding write retiring this cycle is forwarded by the register file.
  assign hazard1 = cnt_q[src1] != '0 && !(wb_en && wb_addr == src1 && cnt_q[src1] == CNT_W'(1));
  assign hazard2 = dec_uses_src2 && cnt_q[src2] != '0 && !(wb_en && wb_addr == src2 && cnt_q[src2] == CNT_W'(1));
  // A saturated destination may still issue when one of its writes retires this cycle.
  assign full    = dec_writes && (&cnt_q[dest]) && !(wb_en && wb_addr == dest);
  assign stall   = dec_valid && (hazard1 || hazard2 || full);
  assign issue   = dec_valid && !stall;
  assign stall_F = stall;
  assign stall_D = stall;
  assign bubble_E = stall;
  assign flush_D = issue && branchD && branch_taken;
  assign sb_err  = sb_err_q;

  always_comb begin
    pending_any = 1'b0;
    for (int r = 0; r < 16; r++) begin
      cnt_d[r] = cnt_q[r]
               + CNT_W'(issue && dec_writes && dest == 4'(r))
               - CNT_W'(wb_en && wb_addr == 4'(r) && cnt_q[r] != '0);
      pending_any = pending_any | (cnt_q[r] != '0);
    end
    sb_err_d = sb_err_q | (wb_en && cnt_q[wb_addr] == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '{default: '0};
      sb_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sb_err_q <= sb_err_d;
    end
  end
endmodule
